// File: rtl/password_check_pkg.sv
// Shared types and constants for the locker password checker.
package lock_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_e;

  localparam int unsigned DEF_DIGITS  = 4;
  localparam int unsigned DEF_DIGIT_W = 4;

  function automatic int unsigned pw_width(input int unsigned digits,
                                           input int unsigned digit_w);
    return digits * digit_w;
  endfunction

endpackage

// File: rtl/password_check_if.sv
// Keypad/password/status bundle between the keypad side and the checker.
interface password_check_if
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS    = DEF_DIGITS,
  parameter int unsigned DIGIT_W   = DEF_DIGIT_W,
  parameter int unsigned MAX_TRIES = 3
);

  logic [DIGIT_W-1:0]                    digit_in;
  logic                                  digit_valid;
  logic                                  clear;
  logic [pw_width(DIGITS, DIGIT_W)-1:0]  stored_password;
  logic                                  unlock;
  logic                                  fail_pulse;
  logic                                  locked_out;
  logic [$clog2(DIGITS+1)-1:0]           digit_count;
  logic [$clog2(MAX_TRIES+1)-1:0]        tries_left;

  // Keypad / setter side
  modport master (
    output digit_in, digit_valid, clear, stored_password,
    input  unlock, fail_pulse, locked_out, digit_count, tries_left
  );

  // Checker side
  modport slave (
    input  digit_in, digit_valid, clear, stored_password,
    output unlock, fail_pulse, locked_out, digit_count, tries_left
  );

endinterface

// File: rtl/password_check_lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT hold periods.
module lock_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // Next count: load has priority, otherwise count down and hold at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/password_check.sv
// Locker password verifier: assembles keypad digits, compares against the
// stored password and drives unlock / fail / lockout status.
module password_check
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS         = DEF_DIGITS,
  parameter int unsigned DIGIT_W        = DEF_DIGIT_W,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst_n,
  password_check_if.slave bus
);

  localparam int unsigned PW    = pw_width(DIGITS, DIGIT_W);
  localparam int unsigned CW    = $clog2(DIGITS + 1);
  localparam int unsigned TRW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMAX  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW    = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  state_e           state_q;
  logic [PW-1:0]    entry_q;
  logic [CW-1:0]    count_q;
  logic [TRW-1:0]   tries_q;
  logic             unlock_q;
  logic             fail_q;
  logic             locked_q;

  logic             match;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_done;
  logic [TW-1:0]    tmr_val;

  // Timer control: armed on the CHECK edge, runs only while holding OPEN/LOCKOUT
  always_comb begin
    match    = (entry_q == bus.stored_password);
    tmr_load = (state_q == CHECK);
    tmr_val  = match ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
    tmr_en   = (state_q == OPEN) || (state_q == LOCKOUT);
  end

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Main FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      entry_q  <= '0;
      count_q  <= '0;
      tries_q  <= TRW'(MAX_TRIES);
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (bus.clear) begin
            entry_q <= '0;
            count_q <= '0;
          end else if (bus.digit_valid) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (count_q == CW'(i)) begin
                entry_q[i*DIGIT_W +: DIGIT_W] <= bus.digit_in;
              end
            end
            count_q <= count_q + CW'(1);
            if (count_q == CW'(DIGITS - 1)) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          entry_q <= '0;
          count_q <= '0;
          if (match) begin
            state_q  <= OPEN;
            unlock_q <= 1'b1;
            tries_q  <= TRW'(MAX_TRIES);
          end else begin
            fail_q <= 1'b1;
            if (tries_q == TRW'(1)) begin
              tries_q  <= '0;
              state_q  <= LOCKOUT;
              locked_q <= 1'b1;
            end else begin
              tries_q <= tries_q - TRW'(1);
              state_q <= ENTRY;
            end
          end
        end
        OPEN: begin
          if (bus.clear || tmr_done) begin
            state_q  <= ENTRY;
            unlock_q <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (tmr_done) begin
            state_q  <= ENTRY;
            locked_q <= 1'b0;
            tries_q  <= TRW'(MAX_TRIES);
          end
        end
        default: begin
          state_q <= ENTRY;
        end
      endcase
    end
  end

  assign bus.unlock      = unlock_q;
  assign bus.fail_pulse  = fail_q;
  assign bus.locked_out  = locked_q;
  assign bus.digit_count = count_q;
  assign bus.tries_left  = tries_q;

endmodule
